// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared control encodings for the IF-stage PC redirect logic.
// Holds the reset PC, the redirect FSM states and the B-type branch codes.
package pc_redirect_ctrl_pkg;

  localparam logic [31:0] PCR_RESET_PC = 32'h0000_3000;
  localparam int          PCR_CNT_W    = 16;

  typedef enum logic {
    PCR_RUN  = 1'b0,
    PCR_HOLD = 1'b1
  } pcr_state_t;

  // Branch-type encodings decoded in ID; they share this file with the PC states.
  localparam logic [2:0] B_TYPE_BEQ  = 3'd0;
  localparam logic [2:0] B_TYPE_BNE  = 3'd1;
  localparam logic [2:0] B_TYPE_BGTZ = 3'd2;
  localparam logic [2:0] B_TYPE_BLEZ = 3'd3;
  localparam logic [2:0] B_TYPE_BGEZ = 3'd4;
  localparam logic [2:0] B_TYPE_BLTZ = 3'd5;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// ID/IF redirect bus: branch and jump decode in, fetch PC and flush out.
// master drives the decode side, slave is the PC redirect controller.
interface pc_redirect_ctrl_if #(parameter int CNT_W = 16) ();

  logic              if_wait;
  logic              id_stall;
  logic              is_branch;
  logic              b_result;
  logic [31:0]       branch_target;
  logic              is_jump;
  logic [31:0]       jump_target;
  logic [31:0]       pc;
  logic [31:0]       npc;
  logic              flush_ifid;
  logic              pending;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output if_wait, id_stall, is_branch, b_result, branch_target, is_jump, jump_target,
    input  pc, npc, flush_ifid, pending, redirect_cnt
  );

  modport slave (
    input  if_wait, id_stall, is_branch, b_result, branch_target, is_jump, jump_target,
    output pc, npc, flush_ifid, pending, redirect_cnt
  );

endinterface

// File: rtl/pc_redirect_ctrl_pc_next_sel.sv
// Combinational redirect request, word-aligned target and sequential PC; zero latency.
// No backpressure of its own; the owning FSM applies if_wait.
module pc_redirect_ctrl_pc_next_sel
  import pc_redirect_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        id_stall,
  input  logic        is_branch,
  input  logic        b_result,
  input  logic [31:0] branch_target,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  output logic        req,
  output logic [31:0] tgt,
  output logic [31:0] pc_seq
);

  // is_branch gates b_result first so an undriven comparator output never leaks into req.
  assign req    = !id_stall && (is_jump || (is_branch && (b_result == 1'b1)));
  assign tgt    = align_word(is_jump ? jump_target : branch_target);
  assign pc_seq = pc + 32'd4;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with branch/jump redirect; redirect lands 1 cycle after the request.
// While fetch waits, a redirect is parked in pend_target and applied once if_wait drops.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PCR_RESET_PC,
  parameter int          CNT_W    = PCR_CNT_W
)(
  input  logic               clk,
  input  logic               rst,
  pc_redirect_ctrl_if.slave  bus
);

  pcr_state_t        state;
  logic [31:0]       pc;
  logic [31:0]       pend_target;
  logic [CNT_W-1:0]  cnt;
  logic              pending;
  logic              req;
  logic [31:0]       tgt;
  logic [31:0]       pc_seq;

  pc_redirect_ctrl_pc_next_sel u_next_sel (
    .pc            (pc),
    .id_stall      (bus.id_stall),
    .is_branch     (bus.is_branch),
    .b_result      (bus.b_result),
    .branch_target (bus.branch_target),
    .is_jump       (bus.is_jump),
    .jump_target   (bus.jump_target),
    .req           (req),
    .tgt           (tgt),
    .pc_seq        (pc_seq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PCR_RUN;
      pc          <= RESET_PC;
      pend_target <= 32'd0;
      cnt         <= '0;
      pending     <= 1'b0;
    end else begin
      case (state)
        PCR_RUN: begin
          if (req && !bus.if_wait) begin
            pc  <= tgt;
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          end else if (req) begin
            pend_target <= tgt;
            state       <= PCR_HOLD;
            pending     <= 1'b1;
          end else if (!bus.if_wait && !bus.id_stall) begin
            pc <= pc_seq;
          end
        end
        PCR_HOLD: begin
          // ID holds a bubble here, so any req is ignored and id_stall does not matter.
          if (!bus.if_wait) begin
            pc      <= pend_target;
            cnt     <= (cnt == '1) ? cnt : cnt + 1'b1;
            state   <= PCR_RUN;
            pending <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pc           = pc;
  assign bus.npc          = pc_seq;
  assign bus.flush_ifid   = (state == PCR_RUN) ? req : !bus.if_wait;
  assign bus.pending      = pending;
  assign bus.redirect_cnt = cnt;

endmodule
